// File: rtl/tlb_pkg.sv
// Shared MMU definitions: EntryLo/EntryHi/PageMask field positions, TLB entry
// types, and the replacement LFSR constants. Package name is mmu_pkg.
package mmu_pkg;

   localparam int LO_PFN_LSB  = 6;
   localparam int LO_PFN_W    = 20;
   localparam int LO_C_LSB    = 3;
   localparam int LO_C_W      = 3;
   localparam int LO_D_BIT    = 2;
   localparam int LO_V_BIT    = 1;
   localparam int LO_G_BIT    = 0;

   localparam int HI_VPN2_LSB = 13;
   localparam int HI_VPN2_W   = 19;
   localparam int HI_ASID_W   = 8;

   localparam int MASK_LSB    = 13;
   localparam int MASK_W      = 12;

   localparam logic [31:0] ENTRYHI_MASK = 32'h1fffe000 | 32'h000000ff;

   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   localparam logic [31:0] LFSR_SEED = 32'h00000001;

   typedef struct packed {
      logic [LO_PFN_W-1:0] pfn;
      logic [LO_C_W-1:0]   c;
      logic                d;
      logic                v;
   } tlb_lo_t;

   typedef struct packed {
      logic [HI_VPN2_W-1:0] vpn2;
      logic [HI_ASID_W-1:0] asid;
      logic                 g;
      logic [MASK_W-1:0]    mask;
      tlb_lo_t              lo0;
      tlb_lo_t              lo1;
   } tlb_entry_t;

   // G is held once per entry, so the per-half record drops bit 0.
   function automatic tlb_lo_t unpack_lo(input logic [25:1] w);
      tlb_lo_t lo;
      lo.pfn = w[LO_PFN_LSB +: LO_PFN_W];
      lo.c   = w[LO_C_LSB +: LO_C_W];
      lo.d   = w[LO_D_BIT];
      lo.v   = w[LO_V_BIT];
      return lo;
   endfunction

   function automatic logic [31:0] pack_lo(input tlb_lo_t lo, input logic g);
      return {6'b0, lo.pfn, lo.c, lo.d, lo.v, g};
   endfunction

   function automatic logic [3:0] mask_pages(input logic [MASK_W-1:0] m);
      logic [3:0] n;
      n = '0;
      for (int j = 0; j < MASK_W; j++) n = n + {3'b0, m[j]};
      return n;
   endfunction

endpackage

// File: rtl/tlb_if.sv
// MMU <-> TLB bus: lookup, entry write/read-back and random replacement index.
interface tlb_if;
   logic [31:0] vAddr;
   logic [31:0] pAddr;
   logic [31:0] entryHiIn;
   logic [31:0] entryLo0In;
   logic [31:0] entryLo1In;
   logic [31:0] pageMaskIn;
   logic [31:0] index;
   logic        we;
   logic        re;
   logic        found;
   logic        bitV;
   logic        bitD;
   logic [2:0]  bitC;
   logic [31:0] entryHiOut;
   logic [31:0] entryLo0Out;
   logic [31:0] entryLo1Out;
   logic [31:0] pageMaskOut;
   logic [31:0] matchedIndex;
   logic [31:0] randomOut;
   logic [31:0] randomIndex;

   modport master (
      output vAddr, entryHiIn, entryLo0In, entryLo1In, pageMaskIn, index, we, re,
      input  pAddr, found, bitV, bitD, bitC, entryHiOut, entryLo0Out, entryLo1Out,
             pageMaskOut, matchedIndex, randomOut, randomIndex
   );

   modport slave (
      input  vAddr, entryHiIn, entryLo0In, entryLo1In, pageMaskIn, index, we, re,
      output pAddr, found, bitV, bitD, bitC, entryHiOut, entryLo0Out, entryLo1Out,
             pageMaskOut, matchedIndex, randomOut, randomIndex
   );
endinterface

// File: rtl/tlb_random32.sv
// Free-running 32-bit Galois LFSR supplying random TLB replacement indices.
module random32
   import mmu_pkg::*;
(
   input  logic        clk,
   input  logic        res,
   output logic [31:0] out
);

   logic [31:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (res) r_lfsr <= LFSR_SEED;
      else     r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
   end

   assign out = r_lfsr;

endmodule

// File: rtl/tlb.sv
// Fully associative joint TLB, even/odd page pairs, combinational lookup.
// Optional TLB_DEBUG_DISPLAY_EN traces every entry write and read.
module tlb
   import mmu_pkg::*;
#(
   parameter int ENTRY_ADDR_WIDTH = 4
)(
   input  logic clk,
   input  logic res,
   tlb_if.slave bus
);

   localparam int NUM_ENTRIES = 1 << ENTRY_ADDR_WIDTH;

   tlb_entry_t                  r_entry [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]      r_valid;
   logic [31:0]                 r_hiOut, r_lo0Out, r_lo1Out, r_maskOut;

   logic [31:0]                 w_rand;
   logic [ENTRY_ADDR_WIDTH-1:0] w_idx;
   tlb_entry_t                  w_wrEntry;
   logic [NUM_ENTRIES-1:0]      w_match;
   logic [ENTRY_ADDR_WIDTH-1:0] w_hitIdx;
   logic                        w_found;
   logic [MASK_W-1:0]           w_hitMask;
   logic [4:0]                  w_selPos;
   tlb_lo_t                     w_lo;
   logic [31:0]                 w_offMask;
   logic [31:0]                 w_rdHi, w_rdLo0, w_rdLo1, w_rdMask;

   random32 u_rand (.clk(clk), .res(res), .out(w_rand));

   assign w_idx = bus.index[ENTRY_ADDR_WIDTH-1:0];

   always_comb begin
      w_wrEntry      = '0;
      w_wrEntry.vpn2 = bus.entryHiIn[31:13] & ENTRYHI_MASK[31:13];
      w_wrEntry.asid = bus.entryHiIn[7:0] & ENTRYHI_MASK[7:0];
      w_wrEntry.g    = bus.entryLo0In[LO_G_BIT] & bus.entryLo1In[LO_G_BIT];
      w_wrEntry.mask = bus.pageMaskIn[MASK_LSB +: MASK_W];
      w_wrEntry.lo0  = unpack_lo(bus.entryLo0In[25:1]);
      w_wrEntry.lo1  = unpack_lo(bus.entryLo1In[25:1]);
   end

   // Masked VPN2 bits are don't-care in the compare.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
         logic [HI_VPN2_W-1:0] w_cmpMask;
         assign w_cmpMask   = ~{{(HI_VPN2_W-MASK_W){1'b0}}, r_entry[gi].mask};
         assign w_match[gi] = r_valid[gi]
            && ((r_entry[gi].vpn2 & w_cmpMask) == (bus.vAddr[31:13] & w_cmpMask))
            && (r_entry[gi].g || (r_entry[gi].asid == bus.entryHiIn[7:0]));
      end
   endgenerate

   // Scan downward so the lowest matching index is the one left standing.
   always_comb begin
      w_hitIdx = '0;
      for (int i = NUM_ENTRIES-1; i >= 0; i--)
         if (w_match[i]) w_hitIdx = ENTRY_ADDR_WIDTH'(i);
   end

   assign w_found   = |w_match;
   assign w_hitMask = r_entry[w_hitIdx].mask;
   assign w_selPos  = 5'd12 + {1'b0, mask_pages(w_hitMask)};
   assign w_lo      = bus.vAddr[w_selPos] ? r_entry[w_hitIdx].lo1 : r_entry[w_hitIdx].lo0;
   assign w_offMask = {8'b0, w_hitMask, 12'hfff};

   assign bus.found        = w_found;
   assign bus.pAddr        = w_found ? (({w_lo.pfn, 12'b0} & ~w_offMask) | (bus.vAddr & w_offMask))
                                     : bus.vAddr;
   assign bus.bitV         = w_found & w_lo.v;
   assign bus.bitD         = w_found & w_lo.d;
   assign bus.bitC         = w_found ? w_lo.c : 3'b0;
   assign bus.matchedIndex = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, w_hitIdx};
   assign bus.randomOut    = w_rand;
   assign bus.randomIndex  = {{(32-ENTRY_ADDR_WIDTH){1'b0}}, w_rand[ENTRY_ADDR_WIDTH-1:0]};

   assign w_rdHi   = {r_entry[w_idx].vpn2, 5'b0, r_entry[w_idx].asid};
   assign w_rdLo0  = pack_lo(r_entry[w_idx].lo0, r_entry[w_idx].g);
   assign w_rdLo1  = pack_lo(r_entry[w_idx].lo1, r_entry[w_idx].g);
   assign w_rdMask = {7'b0, r_entry[w_idx].mask, 13'b0};

   // Entry payload is not reset; r_valid alone gates lookup.
   always_ff @(posedge clk) begin
      if (!res && bus.we) r_entry[w_idx] <= w_wrEntry;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_valid   <= '0;
         r_hiOut   <= '0;
         r_lo0Out  <= '0;
         r_lo1Out  <= '0;
         r_maskOut <= '0;
      end else begin
         if (bus.we) r_valid[w_idx] <= 1'b1;
         if (bus.re) begin
            r_hiOut   <= w_rdHi;
            r_lo0Out  <= w_rdLo0;
            r_lo1Out  <= w_rdLo1;
            r_maskOut <= w_rdMask;
         end
      end
   end

   assign bus.entryHiOut  = r_hiOut;
   assign bus.entryLo0Out = r_lo0Out;
   assign bus.entryLo1Out = r_lo1Out;
   assign bus.pageMaskOut = r_maskOut;

`ifdef TLB_DEBUG_DISPLAY_EN
   always_ff @(posedge clk) begin
      if (!res && bus.we)
         $display("[TLB] write idx=%0d hi=%h lo0=%h lo1=%h mask=%h", w_idx,
                  bus.entryHiIn & ENTRYHI_MASK, bus.entryLo0In, bus.entryLo1In, bus.pageMaskIn);
      if (!res && bus.re)
         $display("[TLB] read idx=%0d hi=%h lo0=%h lo1=%h mask=%h", w_idx,
                  w_rdHi, w_rdLo0, w_rdLo1, w_rdMask);
   end
`else
   // Silent build: no trace output.
`endif

endmodule

// File: tb/tb_tlb.sv
// Directed + random checks of tlb against a page-size arithmetic reference model.
module tb_tlb;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   tlb_if bus();

   tlb #(.ENTRY_ADDR_WIDTH(4)) u_dut (.clk(clk), .res(res), .bus(bus.slave));

   int n_assert = 0;
   int n_fail   = 0;

   bit          m_valid [16];
   logic [31:0] m_hi [16], m_lo0 [16], m_lo1 [16], m_mask [16];
   logic [31:0] m_hiOut, m_lo0Out, m_lo1Out, m_maskOut, m_lfsr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic g_of(input int i);
      return m_lo0[i][0] & m_lo1[i][0];
   endfunction

   function automatic logic [31:0] exp_lo(input logic [31:0] w, input logic g);
      return (w & 32'h03fffffe) | {31'h0, g};
   endfunction

   task automatic tick();
      bit r;
      r = res;
      @(posedge clk);
      m_lfsr = r ? 32'h1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0));
      #1;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_hiOut"},   bus.entryHiOut,  m_hiOut);
      chk({tag, "_lo0Out"},  bus.entryLo0Out, m_lo0Out);
      chk({tag, "_lo1Out"},  bus.entryLo1Out, m_lo1Out);
      chk({tag, "_maskOut"}, bus.pageMaskOut, m_maskOut);
   endtask

   task automatic do_op(input bit we, input bit re, input int idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] mask);
      bus.index = idx; bus.entryHiIn = hi; bus.entryLo0In = lo0;
      bus.entryLo1In = lo1; bus.pageMaskIn = mask; bus.we = we; bus.re = re;
      if (re) begin
         m_hiOut   = m_hi[idx] & 32'h1fffe0ff;
         m_lo0Out  = exp_lo(m_lo0[idx], g_of(idx));
         m_lo1Out  = exp_lo(m_lo1[idx], g_of(idx));
         m_maskOut = m_mask[idx] & 32'h01ffe000;
      end
      tick();
      if (we) begin
         m_valid[idx] = 1'b1; m_hi[idx] = hi; m_lo0[idx] = lo0;
         m_lo1[idx] = lo1; m_mask[idx] = mask;
      end
      bus.we = 1'b0; bus.re = 1'b0;
      if (re) chk_outs("rd");
   endtask

   // Pair span is 8K << n; the entry matches when everything above it agrees.
   task automatic look(input string tag, input logic [31:0] va, input logic [7:0] asid);
      bit f; int hit, n; logic [31:0] pa, hi, lo, ps; logic v, d; logic [2:0] c;
      f = 0; hit = 0; pa = va; v = 0; d = 0; c = 0;
      bus.vAddr = va; bus.entryHiIn = {24'h0, asid};
      #1;
      for (int i = 0; i < 16; i++) begin
         if (f || !m_valid[i]) continue;
         hi = m_hi[i] & 32'h1fffe0ff;
         n  = $countones(m_mask[i] & 32'h01ffe000);
         if ((hi >> (13 + n)) != (va >> (13 + n))) continue;
         if (!g_of(i) && hi[7:0] != asid) continue;
         f = 1; hit = i; ps = 32'h1000 << n;
         lo = va[12 + n] ? m_lo1[i] : m_lo0[i];
         pa = ({lo[25:6], 12'h0} & ~(ps - 1)) | (va & (ps - 1));
         v = lo[1]; d = lo[2]; c = lo[5:3];
      end
      chk({tag, "_found"}, 32'(bus.found), 32'(f));
      chk({tag, "_idx"},   bus.matchedIndex, 32'(hit));
      chk({tag, "_pAddr"}, bus.pAddr, pa);
      chk({tag, "_V"},     32'(bus.bitV), 32'(v));
      chk({tag, "_D"},     32'(bus.bitD), 32'(d));
      chk({tag, "_C"},     32'(bus.bitC), 32'(c));
      chk({tag, "_rnd"},   bus.randomIndex, m_lfsr & 32'hf);
   endtask

   initial begin
      int op, idx, k, n;
      logic [31:0] hi, va, mask;

      res = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.vAddr = '0; bus.index = '0;
      bus.entryHiIn = '0; bus.entryLo0In = '0; bus.entryLo1In = '0; bus.pageMaskIn = '0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; m_mask[i] = '0;
      end
      m_hiOut = '0; m_lo0Out = '0; m_lo1Out = '0; m_maskOut = '0;

      tick(); tick();
      chk("rst_lfsr", u_dut.u_rand.out, 32'h00000001);
      chk_outs("rst");
      look("rst_look", 32'h00400000, 8'h0);
      chk("rst_found", 32'(bus.found), 32'h0);
      res = 1'b0;
      tick();
      chk("lfsr_step", bus.randomOut, 32'h80200003);

      // 4K pair at index 3
      do_op(1, 0, 3, 32'h00400000, 32'h0000401e, 32'h00008002, 32'h0);
      look("w3_even", 32'h00400abc, 8'h0);
      chk("w3_even_pa", bus.pAddr, 32'h00100abc);
      chk("w3_even_mi", bus.matchedIndex, 32'd3);
      chk("w3_even_c",  32'(bus.bitC), 32'd3);
      look("w3_odd", 32'h00401abc, 8'h0);
      chk("w3_odd_pa", bus.pAddr, 32'h00200abc);

      look("asid_miss", 32'h00400abc, 8'h5);
      chk("asid_miss_found", 32'(bus.found), 32'h0);
      chk("asid_miss_pa", bus.pAddr, 32'h00400abc);
      do_op(1, 0, 3, 32'h00400000, 32'h0000401f, 32'h00008003, 32'h0);
      look("global_hit", 32'h00400abc, 8'h5);
      chk("global_hit_found", 32'(bus.found), 32'h1);

      // 16K pair at index 5
      do_op(1, 0, 5, 32'h00400000, 32'h0, 32'h00008003, 32'h00006000);
      look("p16k", 32'h00406123, 8'h0);
      chk("p16k_pa", bus.pAddr, 32'h00202123);
      chk("p16k_mi", bus.matchedIndex, 32'd5);

      do_op(0, 1, 3, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("rb3_hi",  bus.entryHiOut,  32'h00400000);
      chk("rb3_lo0", bus.entryLo0Out, 32'h0000401f);
      chk("rb3_lo1", bus.entryLo1Out, 32'h00008003);

      // Same-cycle write+read returns the old contents
      do_op(1, 1, 3, 32'hffffffff, 32'hffffffff, 32'h12345678, 32'h0000e000);
      chk("wr_rd_old_hi", bus.entryHiOut, 32'h00400000);
      do_op(0, 1, 3, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("wr_rd_new_hi",   bus.entryHiOut,  32'h1fffe0ff);
      chk("wr_rd_new_lo0",  bus.entryLo0Out, 32'h03fffffe);
      chk("wr_rd_new_lo1",  bus.entryLo1Out, 32'h02345678);
      chk("wr_rd_new_mask", bus.pageMaskOut, 32'h0000e000);

      do_op(1, 0, 7, 32'h00800000, 32'h1, 32'h1, 32'h0);
      do_op(1, 0, 2, 32'h00800000, 32'h1, 32'h1, 32'h0);
      look("dup", 32'h00800123, 8'h9);
      chk("dup_mi", bus.matchedIndex, 32'd2);

      // Reset beats a concurrent write/read
      bus.index = 4; bus.entryHiIn = 32'h00c00000; bus.entryLo0In = 32'h1;
      bus.entryLo1In = 32'h1; bus.pageMaskIn = '0; bus.we = 1'b1; bus.re = 1'b1; res = 1'b1;
      tick();
      res = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_hiOut = '0; m_lo0Out = '0; m_lo1Out = '0; m_maskOut = '0;
      chk_outs("midrst");
      look("midrst_dup", 32'h00800123, 8'h9);
      look("midrst_w4", 32'h00c00000, 8'h0);
      chk("midrst_lfsr", bus.randomOut, 32'h00000001);

      for (int it = 0; it < 300; it++) begin
         op  = $urandom_range(0, 9);
         idx = $urandom_range(0, 15);
         if (op < 4 || ((op == 4 || op == 5) && !m_valid[idx])) begin
            n    = $urandom_range(0, 5);
            mask = ((32'h1 << n) - 1) << 13;
            hi   = (32'($urandom_range(0, 7)) << 23) | ($urandom & 32'he07fff00)
                 | 32'($urandom_range(0, 3));
            do_op(1, 0, idx, hi, $urandom, $urandom, mask);
         end else if (op == 4) begin
            do_op(0, 1, idx, $urandom, $urandom, $urandom, 32'h0);
         end else if (op == 5) begin
            n    = $urandom_range(0, 5);
            mask = ((32'h1 << n) - 1) << 13;
            do_op(1, 1, idx, $urandom, $urandom, $urandom, mask);
         end else begin
            tick();
         end
         k = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0)
            va = $urandom;
         else
            va = (m_hi[k] & 32'h1fffe000)
               ^ ($urandom & ((32'h2000 << $urandom_range(0, 6)) - 1));
         look("rnd", va, 8'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb.md
# tlb

Fully associative, MIPS-style joint TLB for the MMU, with a free-running pseudo-random generator sub-module that supplies random replacement indices. Each entry maps an even/odd virtual page pair to two physical frames. Lookup is combinational on the virtual address. Entries are written and read back through the MMU's EntryHi, EntryLo0/1 and PageMask registers.

## Interface
- ENTRY_ADDR_WIDTH, 4, log2 of entry count (16 entries)
- clk  in  1  clock
- res  in  1  reset; one clock, synchronous and active-high
- vAddr  in  32  virtual address to translate or probe
- pAddr  out  32  translated physical address (comb)
- entryHiIn  in  32  VPN2 [31:13], current ASID [7:0]
- entryLo0In, entryLo1In  in  32  each: PFN [25:6], C [5:3], D [2], V [1], G [0]
- pageMaskIn  in  32  mask [24:13]
- index  in  32  entry for write/read; only low ENTRY_ADDR_WIDTH bits used
- we  in  1  write entry[index]
- re  in  1  read entry[index] to *Out
- found  out  1  some entry matches vAddr (comb)
- bitV, bitD  out  1  V and D of the selected half of the matching entry (comb)
- bitC  out  3  C of the selected half (comb)
- entryHiOut, entryLo0Out, entryLo1Out, pageMaskOut  out  32  registered read-back
- matchedIndex  out  32  matching entry index, zero-extended (comb)

## Operation
- Stored per entry:
  - VPN2 [31:13], ASID [7:0], G
  - mask [24:13]
  - Lo0/Lo1: PFN, C, D, V each
- Write: entryHi is stored masked to VPN2 | ASID; other bits read back 0.
- Write: G = entryLo0In[0] & entryLo1In[0]; read-back G bit of both Lo words = stored G.
- Match for entry i: all three must hold:
  - (VPN2_i & ~mask_i) == (vAddr[31:13] & ~mask_i)
  - G_i or ASID_i == entryHiIn[7:0]
  - entry written since reset
- Multiple matches: lowest index wins.
- Odd/even select bit = vAddr[12+n], where n = popcount(mask_i). Supported masks are contiguous ones from bit 13 (4K to 16M pages). Select bit 1 uses Lo1, 0 uses Lo0.
- Offset mask: bits [11:0] all ones; bit k (12..23) = mask_i[k+1].
- pAddr = ({PFN,12'b0} & ~offsetMask) | (vAddr & offsetMask).
- No match:
  - found=0, bitV=0, bitD=0, bitC=0
  - pAddr = vAddr
  - matchedIndex = 0
- bitD is passed through unchanged; fault interpretation is the MMU's job.

## Timing
- Lookup outputs are purely combinational from vAddr, entryHiIn and array state.
- Write: takes effect at the posedge with we=1; visible to lookup the following cycle.
- Read: *Out registered at the posedge with re=1; held until the next read.
- we and re in the same cycle on the same index: read returns the pre-write contents.
- Reset:
  - all entries marked unwritten
  - *Out = 0
  - random generator reseeded
- Reset asserted mid-operation wins over we/re in that cycle.

## Configuration
- TLB_DEBUG_DISPLAY_EN: when defined, every write and read prints index and the four words via $display, tagged "[TLB]".
- Without it: no display statements; function identical.

## Structure
- Shared package `mmu_pkg` holds:
  - field positions: PFN, C, D, V, G, VPN2, ASID, mask bits
  - ENTRYHI_MASK 32'h1fffe000 | 32'h000000ff
  - LFSR taps
- Sub-module `random32`:
  - ports clk, res, out[31:0]
  - 32-bit Galois LFSR, reset to 32'h00000001, advances every clock
  - next = {1'b0,out[31:1]} ^ (out[0] ? 32'h80200003 : 0)
  - MMU uses its low ENTRY_ADDR_WIDTH bits as the random write index.

## Test plan
- Reset:
  - found=0 for vAddr 0x00400000
  - *Out = 0
  - random32 out 0x00000001, then 0x80200003 one clock later
- Write index 3:
  - Inputs: Hi 0x00400000 (ASID 0), Lo0 PFN 0x100 (C=3, V=1, D=1), Lo1 PFN 0x200 (V=1), mask 0.
  - Lookup vAddr 0x00400ABC: found=1, matchedIndex=3, pAddr=0x00100ABC, bitC=3.
  - Lookup vAddr 0x00401ABC: pAddr=0x00200ABC.
- ASID/G:
  - Same entry with G=0; set entryHiIn ASID 5: found=0.
  - Rewrite with both G=1: found=1.
- 16K page: mask 0x00006000, VPN2 0x00400000 >> 13.
  - vAddr 0x00406123 selects Lo1: pAddr = {PFN1,12'b0} & ~0x3FFF | 0x2123.
- Read-back: re with index 3 -> entryHiOut 0x00400000, Lo words as written one clock later.
- Simultaneous we+re on the same index returns old data.
- Duplicate matches at entries 2 and 7: matchedIndex = 2.
